// File: rtl/binary_window_filter.sv
// Binary majority filter over WIN x WIN windows on a STEP grid, read from a sync-read frame buffer.
// Define FILTER_STALL_EN to add a stall input that freezes the scan, pipeline and drain counter.
module binary_window_filter #(
    parameter int unsigned IMG_W   = 240,
    parameter int unsigned IMG_H   = 180,
    parameter int unsigned WIN     = 3,
    parameter int unsigned STEP    = 1,
    parameter int unsigned THRESH  = WIN * WIN / 2,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  x_addr,
    output logic [ADDR_W-1:0]  y_addr,
    input  logic               data_in,
    output logic               out_valid,
    output logic               out_pixel,
    output logic [ADDR_W-1:0]  out_x,
    output logic [ADDR_W-1:0]  out_y,
    output logic [COUNT_W-1:0] active_count
`ifdef FILTER_STALL_EN
    ,
    input  logic               stall
`endif
);

    localparam int unsigned D_W   = $clog2(WIN);
    localparam int unsigned SUM_W = $clog2(WIN * WIN + 1);

    localparam logic [D_W-1:0]    D_LAST   = D_W'(WIN - 1);
    localparam logic [ADDR_W:0]   STEP_EXT = (ADDR_W + 1)'(STEP);
    localparam logic [ADDR_W:0]   X_LIM    = (ADDR_W + 1)'(IMG_W - WIN);
    localparam logic [ADDR_W:0]   Y_LIM    = (ADDR_W + 1)'(IMG_H - WIN);
    localparam logic [ADDR_W-1:0] STEP_A   = ADDR_W'(STEP);
    localparam logic [SUM_W-1:0]  THRESH_S = SUM_W'(THRESH);

    typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic               r_drain;
    logic               r_done;
    logic               w_done_next;

    logic [ADDR_W-1:0]  r_ox;
    logic [ADDR_W-1:0]  r_oy;
    logic [D_W-1:0]     r_dx;
    logic [D_W-1:0]     r_dy;

    logic               r_p1_valid;
    logic               r_p1_first;
    logic               r_p1_last;
    logic [ADDR_W-1:0]  r_p1_ox;
    logic [ADDR_W-1:0]  r_p1_oy;
    logic [SUM_W-1:0]   r_sum;

    logic               r_out_valid;
    logic               r_out_pixel;
    logic [ADDR_W-1:0]  r_out_x;
    logic [ADDR_W-1:0]  r_out_y;
    logic [COUNT_W-1:0] r_count;

    logic               w_stall;
    logic               w_adv;
    logic               w_accept;
    logic               w_win_last;
    logic               w_x_wrap;
    logic               w_y_end;
    logic               w_scan_end;
    logic               w_emit;
    logic [SUM_W-1:0]   w_sum_next;
    logic               w_result;

`ifdef FILTER_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_adv      = ~w_stall;
    assign w_accept   = (r_state == StIdle) && start;
    assign w_win_last = (r_dx == D_LAST) && (r_dy == D_LAST);
    // Wrap when the next origin would push the window past the image edge.
    assign w_x_wrap   = ({1'b0, r_ox} + STEP_EXT) > X_LIM;
    assign w_y_end    = ({1'b0, r_oy} + STEP_EXT) > Y_LIM;
    assign w_scan_end = w_win_last && w_x_wrap && w_y_end;

    assign w_sum_next = (r_p1_first ? '0 : r_sum) + {{(SUM_W - 1){1'b0}}, data_in};
    assign w_result   = w_sum_next > THRESH_S;
    assign w_emit     = r_p1_valid && r_p1_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_drain <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            if (r_state == StDrain && w_adv) begin
                r_drain <= ~r_drain;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StScan;
                end
            end
            StScan: begin
                if (w_adv && w_scan_end) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (w_adv && r_drain) begin
                    w_state_next = StIdle;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ox <= '0;
            r_oy <= '0;
            r_dx <= '0;
            r_dy <= '0;
        end else if (w_accept) begin
            r_ox <= '0;
            r_oy <= '0;
            r_dx <= '0;
            r_dy <= '0;
        end else if (r_state == StScan && w_adv) begin
            if (r_dx != D_LAST) begin
                r_dx <= r_dx + 1'b1;
            end else begin
                r_dx <= '0;
                if (r_dy != D_LAST) begin
                    r_dy <= r_dy + 1'b1;
                end else begin
                    r_dy <= '0;
                    if (!w_x_wrap) begin
                        r_ox <= r_ox + STEP_A;
                    end else begin
                        r_ox <= '0;
                        r_oy <= w_y_end ? '0 : r_oy + STEP_A;
                    end
                end
            end
        end
    end

    // Stage 1 tags the address issued last cycle; data_in for it arrives now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p1_valid <= 1'b0;
            r_p1_first <= 1'b0;
            r_p1_last  <= 1'b0;
            r_p1_ox    <= '0;
            r_p1_oy    <= '0;
            r_sum      <= '0;
        end else if (w_adv) begin
            r_p1_valid <= (r_state == StScan);
            r_p1_first <= (r_dx == '0) && (r_dy == '0);
            r_p1_last  <= w_win_last;
            r_p1_ox    <= r_ox;
            r_p1_oy    <= r_oy;
            if (r_p1_valid) begin
                r_sum <= w_sum_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_pixel <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_count     <= '0;
        end else begin
            if (w_adv) begin
                r_out_valid <= w_emit;
                if (w_emit) begin
                    r_out_pixel <= w_result;
                    r_out_x     <= r_p1_ox;
                    r_out_y     <= r_p1_oy;
                    if (w_result && (r_count != '1)) begin
                        r_count <= r_count + COUNT_W'(1);
                    end
                end
            end
            if (w_accept) begin
                r_count <= '0;
            end
        end
    end

    // A result held under stall is masked here and shows once stall drops.
    assign out_valid    = r_out_valid & ~w_stall;
    assign out_pixel    = r_out_pixel;
    assign out_x        = r_out_x;
    assign out_y        = r_out_y;
    assign active_count = r_count;
    assign busy         = (r_state != StIdle);
    assign done         = r_done;
    assign x_addr       = r_ox + {{(ADDR_W - D_W){1'b0}}, r_dx};
    assign y_addr       = r_oy + {{(ADDR_W - D_W){1'b0}}, r_dy};

endmodule

// File: tb/tb_binary_window_filter.sv
// Scoreboard bench: 6x5/WIN3/STEP1 and 7x7/WIN3/STEP2 instances fed from small image arrays.
module tb_binary_window_filter;

    localparam int unsigned AW = 8;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic          pix;
        logic [AW-1:0] x;
        logic [AW-1:0] y;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst_n;
    logic          start1, busy1, done1, din1, ov1, op1;
    logic [AW-1:0] xa1, ya1, ox1, oy1;
    logic [CW-1:0] cnt1;
    logic          start2, busy2, done2, din2, ov2, op2;
    logic [AW-1:0] xa2, ya2, ox2, oy2;
    logic [CW-1:0] cnt2;
`ifdef FILTER_STALL_EN
    logic          stall1, stall2;
`endif

    bit img1 [64];
    bit img2 [64];
    always @(posedge clk) din1 <= img1[int'(ya1) * 6 + int'(xa1)];
    always @(posedge clk) din2 <= img2[int'(ya2) * 7 + int'(xa2)];

    binary_window_filter #(
        .IMG_W(6), .IMG_H(5), .WIN(3), .STEP(1), .ADDR_W(AW), .COUNT_W(CW)
    ) u_dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .busy(busy1), .done(done1),
        .x_addr(xa1), .y_addr(ya1), .data_in(din1), .out_valid(ov1), .out_pixel(op1),
        .out_x(ox1), .out_y(oy1), .active_count(cnt1)
`ifdef FILTER_STALL_EN
        , .stall(stall1)
`endif
    );

    binary_window_filter #(
        .IMG_W(7), .IMG_H(7), .WIN(3), .STEP(2), .ADDR_W(AW), .COUNT_W(CW)
    ) u_dut2 (
        .clk(clk), .reset(rst_n), .start(start2), .busy(busy2), .done(done2),
        .x_addr(xa2), .y_addr(ya2), .data_in(din2), .out_valid(ov2), .out_pixel(op2),
        .out_x(ox2), .out_y(oy2), .active_count(cnt2)
`ifdef FILTER_STALL_EN
        , .stall(stall2)
`endif
    );

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q1[$];
    exp_t q2[$];
    int   c0 = 0;
    int   ov_cnt1 = 0, done_cnt1 = 0, first_ov1 = -1, last_ov1 = -1;
    int   ov_cnt2 = 0, max_xa2 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done1) done_cnt1++;
                if (ov1) begin
                    ov_cnt1++;
                    last_ov1 = cyc;
                    if (first_ov1 < 0) first_ov1 = cyc;
                    if (q1.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL dut1_extra_result: got (%0d,%0d), expected none", ox1, oy1);
                    end else begin
                        e = q1.pop_front();
                        check("dut1_result", 64'({op1, ox1, oy1, cnt1}), 64'(e));
                    end
                end
            end
        end
    end

    initial begin : mon2
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (busy2 && int'(xa2) > max_xa2) max_xa2 = int'(xa2);
                if (ov2) begin
                    ov_cnt2++;
                    if (q2.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL dut2_extra_result: got (%0d,%0d), expected none", ox2, oy2);
                    end else begin
                        e = q2.pop_front();
                        check("dut2_result", 64'({op2, ox2, oy2, cnt2}), 64'(e));
                    end
                end
            end
        end
    end

    // Call at a negedge; returns 1 time unit after the accept edge (cycle 1).
    task automatic start_scan1();
        ov_cnt1   = 0;
        first_ov1 = -1;
        last_ov1  = -1;
        start1    = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        c0     = cyc;
    endtask

    task automatic start_scan2();
        ov_cnt2 = 0;
        max_xa2 = 0;
        start2  = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        c0     = cyc;
    endtask

    task automatic wait_done1(input int exp_k);
        int k;
        k = -1;
        for (int i = 0; i < 2000 && k < 0; i++) begin
            @(negedge clk);
            if (done1) k = cyc - c0 + 1;
        end
        check("dut1_done_cycle", 64'(k), 64'(exp_k));
        check("dut1_busy_at_done", 64'(busy1), 64'(0));
    endtask

    task automatic wait_done2(input int exp_k);
        int k;
        k = -1;
        for (int i = 0; i < 2000 && k < 0; i++) begin
            @(negedge clk);
            if (done2) k = cyc - c0 + 1;
        end
        check("dut2_done_cycle", 64'(k), 64'(exp_k));
    endtask

    task automatic push_ones1();
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            e.pix = 1'b1;
            e.x   = AW'(i % 4);
            e.y   = AW'(i / 4);
            e.cnt = CW'(i + 1);
            q1.push_back(e);
        end
    endtask

    task automatic push2(input bit ones);
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            e.pix = ones;
            e.x   = AW'((i % 3) * 2);
            e.y   = AW'((i / 3) * 2);
            e.cnt = ones ? CW'(i + 1) : CW'(0);
            q2.push_back(e);
        end
    endtask

    task automatic check_tail1(input int exp_cnt);
        check("dut1_result_count", 64'(ov_cnt1), 64'(12));
        check("dut1_active_count", 64'(cnt1), 64'(exp_cnt));
        check("dut1_queue_empty", 64'(q1.size()), 64'(0));
    endtask

    initial begin : main
        exp_t e;
        int   saved;
        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
`ifdef FILTER_STALL_EN
        stall1 = 1'b0;
        stall2 = 1'b0;
`endif
        for (int i = 0; i < 64; i++) begin
            img1[i] = 1'b0;
            img2[i] = 1'b0;
        end
        #1;
        check("reset_busy", 64'(busy1), 64'(0));
        check("reset_done", 64'(done1), 64'(0));
        check("reset_out_valid", 64'(ov1), 64'(0));
        check("reset_out_pixel", 64'(op1), 64'(0));
        check("reset_out_xy", 64'({ox1, oy1}), 64'(0));
        check("reset_addr", 64'({xa1, ya1}), 64'(0));
        check("reset_count", 64'(cnt1), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All-ones 6x5: 12 active windows, 108 address cycles.
        for (int i = 0; i < 30; i++) img1[i] = 1'b1;
        push_ones1();
        @(negedge clk);
        start_scan1();
        wait_done1(111);
        check("dut1_first_ov_cycle", 64'(first_ov1 - c0 + 1), 64'(11));
        check("dut1_last_ov_cycle", 64'(last_ov1 - c0 + 1), 64'(110));
        check_tail1(12);

        // Threshold: ones at (1,0),(2,0),(3,0),(1,1),(2,1) -> (0,0) has 4, (1,0) has 5.
        for (int i = 0; i < 30; i++) img1[i] = 1'b0;
        img1[1] = 1'b1;
        img1[2] = 1'b1;
        img1[3] = 1'b1;
        img1[7] = 1'b1;
        img1[8] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            e.pix = (i == 1);
            e.x   = AW'(i % 4);
            e.y   = AW'(i / 4);
            e.cnt = (i >= 1) ? CW'(1) : CW'(0);
            q1.push_back(e);
        end
        @(negedge clk);
        start_scan1();
        wait_done1(111);
        check_tail1(1);

        // Stride 2 on 7x7: all zeros, then all ones.
        push2(1'b0);
        @(negedge clk);
        start_scan2();
        wait_done2(84);
        check("dut2_max_x_addr", 64'(max_xa2), 64'(6));
        check("dut2_zero_count", 64'(cnt2), 64'(0));
        check("dut2_result_count", 64'(ov_cnt2), 64'(9));
        for (int i = 0; i < 49; i++) img2[i] = 1'b1;
        push2(1'b1);
        @(negedge clk);
        start_scan2();
        wait_done2(84);
        check("dut2_ones_count", 64'(cnt2), 64'(9));

        // Start while busy is ignored; start in the done cycle restarts and clears the count.
        for (int i = 0; i < 30; i++) img1[i] = 1'b1;
        push_ones1();
        @(negedge clk);
        start_scan1();
        fork
            begin
                repeat (30) @(negedge clk);
                start1 = 1'b1;
                @(negedge clk);
                start1 = 1'b0;
            end
        join_none
        wait_done1(111);
        check_tail1(12);
        push_ones1();
        start_scan1();
        check("restart_count_cleared", 64'(cnt1), 64'(0));
        check("restart_busy", 64'(busy1), 64'(1));
        wait_done1(111);
        check_tail1(12);

        // Asynchronous reset mid-scan.
        push_ones1();
        @(negedge clk);
        start_scan1();
        repeat (50) @(posedge clk);
        check("midscan_count_before_reset", 64'(cnt1), 64'(5));
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy1), 64'(0));
        check("abort_outputs", 64'({ov1, op1, ox1, oy1}), 64'(0));
        check("abort_addr", 64'({xa1, ya1}), 64'(0));
        check("abort_count", 64'(cnt1), 64'(0));
        q1.delete();
        saved = done_cnt1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(done_cnt1), 64'(saved));
        push_ones1();
        start_scan1();
        wait_done1(111);
        check_tail1(12);

`ifdef FILTER_STALL_EN
        // Stall 5 cycles from cycle 20 and 3 cycles in DRAIN: done moves from 111 to 119.
        push_ones1();
        @(negedge clk);
        start_scan1();
        fork
            begin
                repeat (19) @(posedge clk);
                #1 stall1 = 1'b1;
                repeat (5) @(posedge clk);
                #1 stall1 = 1'b0;
                repeat (89) @(posedge clk);
                #1 stall1 = 1'b1;
                repeat (3) @(posedge clk);
                #1 stall1 = 1'b0;
            end
        join_none
        wait_done1(119);
        check_tail1(12);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/binary_window_filter.md
Name: binary_window_filter

Overview:
- Parametrised successor to the fixed 3x3 binary median scanner.
- Scans a binary image held in an external synchronous-read memory and computes a thresholded majority (binary median) over every WIN x WIN window on a STEP grid.
- For each window it emits one result with its coordinates, keeps a count of active windows, and signals completion through a start/busy/done handshake.
- Sits between the binary frame buffer and the median result memory / activity counter logic.

Parameters:
- IMG_W, 240, image width in pixels (>= WIN)
- IMG_H, 180, image height in pixels (>= WIN)
- WIN, 3, window side length (2..15)
- STEP, 1, window stride in x and y (1..WIN)
- THRESH, WIN*WIN/2 (integer division), window is active when pixel sum > THRESH
- ADDR_W, 8, width of x/y address and coordinate ports (must hold IMG_W-1 and IMG_H-1)
- COUNT_W, 16, width of active_count

Ports:
- clk, input, 1, rising-edge clock
- reset, input, 1, asynchronous active-low reset
- start, input, 1, single-cycle request to begin a full-image scan
- busy, output, 1, scan in progress
- done, output, 1, one-cycle pulse when the final window result has been emitted
- x_addr, output, ADDR_W, pixel column read address
- y_addr, output, ADDR_W, pixel row read address
- data_in, input, 1, pixel value returned one cycle after its address
- out_valid, output, 1, window result valid (one cycle per window)
- out_pixel, output, 1, filtered result (1 when sum > THRESH)
- out_x, output, ADDR_W, window origin column (top-left)
- out_y, output, ADDR_W, window origin row (top-left)
- active_count, output, COUNT_W, count of windows with out_pixel=1 in the current or last scan

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers clear.
  - busy=0, done=0, out_valid=0, out_pixel=0, out_x=0, out_y=0, active_count=0, x_addr=0, y_addr=0.
- FSM states:
  - IDLE: start=1 -> SCAN. On accept, clear active_count and window origin. start is ignored in any other state.
  - SCAN: issue one address per cycle. Move to DRAIN after the last address of the last window.
  - DRAIN: wait 2 cycles for the pipeline to empty, then go to IDLE with a done pulse.
- Scan order:
  - Window origins go row-major: ox = 0, STEP, ... up to IMG_W-WIN; then oy advances by STEP up to IMG_H-WIN.
  - Inside a window, pixels are read row-major: dy 0..WIN-1, dx 0..WIN-1. x_addr=ox+dx, y_addr=oy+dy.
  - An origin whose next step would exceed IMG_W-WIN (or IMG_H-WIN) wraps or terminates. Origins never exceed those limits.
- Timing:
  - The first address is driven in the cycle after the start-accept edge.
  - Windows are back-to-back with no bubbles: WIN*WIN cycles per window.
- Accumulation:
  - data_in for address cycle k is summed in cycle k+1 into a ceil(log2(WIN*WIN+1))-bit sum.
  - The sum restarts at the first pixel of each window.
- Results:
  - out_valid is registered and high exactly 2 cycles after the cycle carrying the window's last address.
  - out_pixel, out_x, out_y and the updated active_count are valid in the same cycle as out_valid.
- active_count saturates at 2^COUNT_W-1 and holds its value after done until the next start is accepted.
- Handshake edges:
  - done pulses one cycle after the final out_valid.
  - busy is high from the cycle after start is accepted through the DRAIN state, and deasserts on the same edge that done asserts.
  - A start in the done cycle is accepted.
- Reset mid-scan aborts immediately. No done pulse is produced and no partial out_valid appears.

Optional Feature:
- FILTER_STALL_EN
- Defined:
  - Adds input port stall (1 bit).
  - While stall=1, address generation, accumulation, the out_valid pipeline and the DRAIN counter all freeze. x_addr/y_addr hold, and out_valid is forced to 0.
  - A result pending at stall assertion is emitted in the first cycle after stall deasserts.
  - data_in is taken as the value for the held address. Memory read data must remain stable while stalled.
- Undefined: no stall port; the scan is never paused.

Test Plan:
- Reset defaults: IMG_W=6, IMG_H=5, WIN=3, STEP=1, all-ones image, start at cycle 0 -> 12 out_valid pulses, every out_pixel=1, origins in order (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2); active_count=12; exactly 108 address cycles; done one cycle after the 12th out_valid.
- Threshold boundary: same dimensions; window (0,0) holds exactly 4 ones and window (1,0) holds exactly 5 ones -> out_pixel=0 for (0,0), 1 for (1,0); active_count increments only on the latter.
- Stride: IMG_W=7, IMG_H=7, WIN=3, STEP=2 -> 9 windows with origins {0,2,4}x{0,2,4}; x_addr never exceeds 6; all-zeros image gives active_count=0 with done asserted.
- Handshake: start pulsed while busy -> ignored, no restart and count unchanged; start in the done cycle -> new scan accepted and active_count cleared to 0.
- Reset mid-scan: reset=0 asynchronously after 50 cycles -> all outputs return to 0 immediately, no done pulse; a subsequent start gives a full correct scan.
- FILTER_STALL_EN: 6x5 all-ones image, stall=1 for 5 cycles at cycle 20 and for 3 cycles during DRAIN -> still 12 results with identical values and order; done delayed by exactly 8 cycles.
